// File: rtl/mem_read_responder_pkg.sv
// Shared constants and FSM encoding for the memory read responder.
// Holds the word width, the state enum and the default latency/out-of-range word.
// Imported by the interface, the storage array and the responder top.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package mem_read_responder_pkg;

    localparam int DEF_WORD_SIZE = `WORD_SIZE;
    localparam int DEF_DEPTH     = 256;
    localparam int DEF_LATENCY   = 2;
    localparam logic [DEF_WORD_SIZE-1:0] DEF_OOR_DATA = '0;

    // Latency counter is 4 bits wide, so LATENCY may range from 1 to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_read_responder_if.sv
// CPU-side read bus: readM / address / data / inputReady.
// The shared data bus is resolved here from the responder's drive value and enable,
// so the bus has exactly one tri-state buffer and it sits in the interface.
interface mem_read_responder_if
    import mem_read_responder_pkg::*;
#(
    parameter int W = DEF_WORD_SIZE
);
    logic         readM;
    logic [W-1:0] address;
    logic         inputReady;
    logic [W-1:0] drv_dat;
    logic         drv_oe;
    wire  [W-1:0] data;

    // Memory side owns the bus only while drv_oe is high; otherwise it floats.
    assign data = drv_oe ? drv_dat : {W{1'bz}};

    modport slave (
        input  readM,
        input  address,
        output inputReady,
        output drv_dat,
        output drv_oe
    );

    modport master (
        output readM,
        output address,
        input  inputReady,
        input  data
    );
endinterface

// File: rtl/mem_read_responder_mem_array.sv
// Word-addressed backing store: synchronous write, combinational read.
// Read of an address >= DEPTH yields OOR_DATA; writes to such addresses are dropped.
// No reset on the storage: contents survive a responder reset.
module mem_array
    import mem_read_responder_pkg::*;
#(
    parameter int           W        = DEF_WORD_SIZE,
    parameter int           DEPTH    = DEF_DEPTH,
    parameter logic [W-1:0] OOR_DATA = DEF_OOR_DATA
) (
    input  logic         clk,
    input  logic         we_i,
    input  logic [W-1:0] waddr_i,
    input  logic [W-1:0] wdata_i,
    input  logic [W-1:0] raddr_i,
    output logic [W-1:0] rdata_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem_q [DEPTH];
    logic         wr_in_range;
    logic         rd_in_range;

    assign wr_in_range = (32'(waddr_i) < DEPTH);
    assign rd_in_range = (32'(raddr_i) < DEPTH);

    // Preload write; the guard keeps high address bits from aliasing into the array.
    always_ff @(posedge clk) begin
        if (we_i && wr_in_range) begin
            mem_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = rd_in_range ? mem_q[raddr_i[AW-1:0]] : OOR_DATA;

endmodule

// File: rtl/mem_read_responder.sv
// Memory-side read responder: latches a CPU read, waits LATENCY cycles, returns the word.
// Latency: request sampled at edge N -> inputReady high in the cycle after edge N+LATENCY.
// Backpressure: CPU holds readM until inputReady; dropping readM early aborts with no pulse.
module mem_read_responder
    import mem_read_responder_pkg::*;
#(
    parameter int                   WORD_SIZE = DEF_WORD_SIZE,
    parameter int                   DEPTH     = DEF_DEPTH,
    parameter int                   LATENCY   = DEF_LATENCY,
    parameter logic [WORD_SIZE-1:0] OOR_DATA  = DEF_OOR_DATA
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_read_responder_if.slave  bus,
    input  logic                 init_we,
    input  logic [WORD_SIZE-1:0] init_addr,
    input  logic [WORD_SIZE-1:0] init_data,
    output logic                 busy,
    output logic [WORD_SIZE-1:0] read_count
);
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic [WORD_SIZE-1:0] read_count_q, read_count_d;
    logic [WORD_SIZE-1:0] mem_rdata;

    // Storage is read at the latched address only; the live address bus is ignored after IDLE.
    mem_array #(
        .W        (WORD_SIZE),
        .DEPTH    (DEPTH),
        .OOR_DATA (OOR_DATA)
    ) u_mem (
        .clk     (clk),
        .we_i    (init_we),
        .waddr_i (init_addr),
        .wdata_i (init_data),
        .raddr_i (addr_q),
        .rdata_o (mem_rdata)
    );

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            rdata_q      <= '0;
            read_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
            read_count_q <= read_count_d;
        end
    end

    // Next-state: accept, count down, capture (read-before-write on the capture edge), hold.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        read_count_d = read_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.readM) begin
                    addr_d  = bus.address;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.readM) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    rdata_d = mem_rdata;
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_READY: begin
                read_count_d = read_count_q + WORD_SIZE'(1);
                state_d      = S_HOLD;
            end
            S_HOLD: begin
                // A continuously held readM is the same request, not a new one.
                if (!bus.readM) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode the registered state directly, so an async reset drops them at once.
    assign bus.inputReady = (state_q == S_READY);
    assign bus.drv_oe     = ((state_q == S_READY) || (state_q == S_HOLD)) && bus.readM;
    assign bus.drv_dat    = rdata_q;
    assign busy           = (state_q != S_IDLE);
    assign read_count     = read_count_q;

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench for mem_read_responder: one LATENCY=2 and one LATENCY=1 instance
// sharing clock, reset and the preload port.
module tb_mem_read_responder;

    logic        clk;
    logic        reset;
    logic        init_we;
    logic [15:0] init_addr;
    logic [15:0] init_data;
    logic        busy_a, busy_b;
    logic [15:0] cnt_a, cnt_b;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    logic [15:0] addr_b [4] = '{16'h0010, 16'h0011, 16'h0000, 16'h0010};
    logic [15:0] exp_b  [4] = '{16'h1234, 16'h5A5A, 16'h0F0F, 16'h1234};

    mem_read_responder_if #(.W(16)) ba ();
    mem_read_responder_if #(.W(16)) bb ();

    mem_read_responder #(.LATENCY(2)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .bus        (ba.slave),
        .init_we    (init_we),
        .init_addr  (init_addr),
        .init_data  (init_data),
        .busy       (busy_a),
        .read_count (cnt_a)
    );

    mem_read_responder #(.LATENCY(1)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .bus        (bb.slave),
        .init_we    (init_we),
        .init_addr  (init_addr),
        .init_data  (init_data),
        .busy       (busy_b),
        .read_count (cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        init_we   = 1'b1;
        init_addr = a;
        init_data = d;
        @(negedge clk);
        init_we   = 1'b0;
    endtask

    // Full LATENCY=2 read on instance A, readM held through the HOLD cycle.
    task automatic read_a(input string tag, input logic [15:0] a, input logic [15:0] exp);
        ba.readM   = 1'b1;
        ba.address = a;
        @(negedge clk);
        chk({tag, "_w1_ir"}, 32'(ba.inputReady), 32'd0);
        @(negedge clk);
        chk({tag, "_w2_ir"}, 32'(ba.inputReady), 32'd0);
        @(negedge clk);
        chk({tag, "_ir"}, 32'(ba.inputReady), 32'd1);
        chk({tag, "_dat"}, 32'(ba.data), 32'(exp));
        @(negedge clk);
        chk({tag, "_hold_ir"}, 32'(ba.inputReady), 32'd0);
        chk({tag, "_hold_dat"}, 32'(ba.data), 32'(exp));
        ba.readM = 1'b0;
        #1;
        chk({tag, "_release_oe"}, 32'(ba.drv_oe), 32'd0);
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(busy_a), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        init_we    = 1'b0;
        init_addr  = '0;
        init_data  = '0;
        ba.readM   = 1'b0;
        ba.address = '0;
        bb.readM   = 1'b0;
        bb.address = '0;
        #2;
        chk("rst_ir",    32'(ba.inputReady), 32'd0);
        chk("rst_busy",  32'(busy_a),        32'd0);
        chk("rst_count", 32'(cnt_a),         32'd0);
        chk("rst_oe",    32'(ba.drv_oe),     32'd0);
        @(negedge clk);
        reset = 1'b0;

        preload(16'h0010, 16'hA5C3);
        preload(16'h0011, 16'h5A5A);
        preload(16'h0000, 16'h0F0F);

        // Basic read, latency 2.
        read_a("basic", 16'h0010, 16'hA5C3);
        chk("basic_count", 32'(cnt_a), 32'd1);

        // Abort during WAIT.
        ba.readM   = 1'b1;
        ba.address = 16'h0010;
        @(negedge clk);
        chk("abort_busy_wait", 32'(busy_a), 32'd1);
        ba.readM = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_ir", 32'(ba.inputReady), 32'd0);
        chk("abort_oe", 32'(ba.drv_oe), 32'd0);
        @(negedge clk);
        chk("abort_ir2", 32'(ba.inputReady), 32'd0);
        chk("abort_count", 32'(cnt_a), 32'd1);

        // Out-of-range write is dropped and out-of-range read returns OOR_DATA.
        preload(16'h0100, 16'hBEEF);
        read_a("oor", 16'h0100, 16'h0000);
        chk("oor_count", 32'(cnt_a), 32'd2);
        read_a("noalias", 16'h0000, 16'h0F0F);
        chk("noalias_count", 32'(cnt_a), 32'd3);

        // Async reset while READY.
        ba.readM   = 1'b1;
        ba.address = 16'h0010;
        repeat (3) @(negedge clk);
        chk("rstmid_ir_before", 32'(ba.inputReady), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rstmid_ir",    32'(ba.inputReady), 32'd0);
        chk("rstmid_oe",    32'(ba.drv_oe),     32'd0);
        chk("rstmid_busy",  32'(busy_a),        32'd0);
        chk("rstmid_count", 32'(cnt_a),         32'd0);
        #1 ba.readM = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        read_a("postrst", 16'h0010, 16'hA5C3);
        chk("postrst_count", 32'(cnt_a), 32'd1);

        // Address change during WAIT plus a write on the capture edge.
        ba.readM   = 1'b1;
        ba.address = 16'h0010;
        @(negedge clk);
        ba.address = 16'h0011;
        @(negedge clk);
        init_we   = 1'b1;
        init_addr = 16'h0010;
        init_data = 16'h1234;
        @(negedge clk);
        init_we = 1'b0;
        chk("rbw_ir",  32'(ba.inputReady), 32'd1);
        chk("rbw_dat", 32'(ba.data),       32'h0000A5C3);
        @(negedge clk);
        chk("rbw_hold_dat", 32'(ba.data), 32'h0000A5C3);
        ba.readM = 1'b0;
        @(negedge clk);
        read_a("after_wr", 16'h0010, 16'h1234);
        chk("after_wr_count", 32'(cnt_a), 32'd3);

        // Four back-to-back reads, LATENCY=1, one-cycle readM gap.
        chk("b_count_start", 32'(cnt_b), 32'd0);
        for (int i = 0; i < 4; i++) begin
            bb.readM   = 1'b1;
            bb.address = addr_b[i];
            @(negedge clk);
            chk($sformatf("b%0d_wait_ir", i), 32'(bb.inputReady), 32'd0);
            @(negedge clk);
            if (bb.inputReady === 1'b1) pulses++;
            chk($sformatf("b%0d_ir", i), 32'(bb.inputReady), 32'd1);
            chk($sformatf("b%0d_dat", i), 32'(bb.data), 32'(exp_b[i]));
            @(negedge clk);
            if (bb.inputReady === 1'b1) pulses++;
            chk($sformatf("b%0d_hold_ir", i), 32'(bb.inputReady), 32'd0);
            bb.readM = 1'b0;
            #1;
            chk($sformatf("b%0d_gap_oe", i), 32'(bb.drv_oe), 32'd0);
            @(negedge clk);
            chk($sformatf("b%0d_gap_oe2", i), 32'(bb.drv_oe), 32'd0);
            chk($sformatf("b%0d_gap_busy", i), 32'(busy_b), 32'd0);
        end
        chk("b_pulses", 32'(pulses), 32'd4);
        chk("b_count", 32'(cnt_b), 32'd4);
        chk("a_count_final", 32'(cnt_a), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
